// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and helpers for the button press classifier.
//   btn_state_t   : classifier FSM state encoding
//   ms_to_cycles  : elaboration-time millisecond to clock-cycle conversion
//   is_held_state : states in which the button is considered held
// Optional feature macro: BTN_DOUBLE_CLICK_EN adds the WAIT_GAP and
// SECOND_HELD states used for double-click detection.
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESSED     = 3'd1,
`ifdef BTN_DOUBLE_CLICK_EN
    ST_LONG_HELD   = 3'd2,
    ST_WAIT_GAP    = 3'd3,
    ST_SECOND_HELD = 3'd4
`else
    ST_LONG_HELD   = 3'd2
`endif
  } btn_state_t;

  // 64-bit product so that 50 MHz * several seconds does not overflow.
  function automatic longint ms_to_cycles(input longint freq, input longint ms);
    return (freq * ms) / 64'sd1000;
  endfunction

  function automatic logic is_held_state(input btn_state_t s);
    logic held;
    held = (s == ST_PRESSED) || (s == ST_LONG_HELD);
`ifdef BTN_DOUBLE_CLICK_EN
    held = held || (s == ST_SECOND_HELD);
`endif
    return held;
  endfunction

endpackage

// File: rtl/press_timer.sv
// -----------------------------------------------------------------------------
// press_timer
// Shared interval counter for the classifier FSM.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   clr             : synchronous clear (has priority over counting)
//   en              : count enable
//   tc              : terminal count value
//   wrap            : 1 = return to 0 after tc, 0 = saturate at tc
//   at_tc           : counter currently equals tc
// -----------------------------------------------------------------------------
module press_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] tc,
  input  logic             wrap,
  output logic             at_tc
);

  logic [WIDTH-1:0] cnt;

  assign at_tc = (cnt == tc);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (at_tc) begin
        if (wrap) cnt <= '0;
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/button_press_classifier.sv
// -----------------------------------------------------------------------------
// button_press_classifier
// Turns a debounced, synchronous button level into single-cycle UI events.
//   clk_i     : clock
//   reset_ni  : asynchronous active-low reset
//   btn_i     : debounced button level, active-high
//   press_o   : pulse on every accepted first press
//   short_o   : pulse when a press is classified short
//   long_o    : pulse when the hold reaches LONG_PRESS_MS
//   repeat_o  : pulse every REPEAT_MS after long_o while held
//   double_o  : pulse on a qualified second press
//   held_o    : high while in PRESSED, LONG_HELD or SECOND_HELD
// Optional feature macro: BTN_DOUBLE_CLICK_EN (double-click detection).
// Without it double_o is tied low and short_o fires one cycle after release.
// WIDTH_COUNTER must hold the largest cycle count; at 50 MHz the default
// 800 ms long press needs 26 bits, so widen it when keeping that timing.
// -----------------------------------------------------------------------------
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int WIDTH_COUNTER = 24,
  parameter int CLOCK_FREQ    = 50_000_000,
  parameter int LONG_PRESS_MS = 800,
  parameter int REPEAT_MS     = 200,
  parameter int DOUBLE_GAP_MS = 250
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_i,
  output logic press_o,
  output logic short_o,
  output logic long_o,
  output logic repeat_o,
  output logic double_o,
  output logic held_o
);

  localparam logic [WIDTH_COUNTER-1:0] LONG_TC =
    WIDTH_COUNTER'(ms_to_cycles(CLOCK_FREQ, LONG_PRESS_MS) - 1);
  localparam logic [WIDTH_COUNTER-1:0] REPEAT_TC =
    WIDTH_COUNTER'(ms_to_cycles(CLOCK_FREQ, REPEAT_MS) - 1);
  localparam logic [WIDTH_COUNTER-1:0] GAP_TC =
    WIDTH_COUNTER'(ms_to_cycles(CLOCK_FREQ, DOUBLE_GAP_MS) - 1);

  btn_state_t state, state_next;
  logic btn_prev, rise, fall;
  logic press_d, short_d, long_d, repeat_d, held_d;
  logic tmr_clr, tmr_en, tmr_wrap, tmr_at_tc;
  logic [WIDTH_COUNTER-1:0] tmr_tc;

  assign rise = btn_i && !btn_prev;
  assign fall = !btn_i && btn_prev;

  // Timer control: restart on every state change, free-run only while holding long.
  assign tmr_clr  = (state_next != state);
  assign tmr_wrap = (state == ST_LONG_HELD);

  always_comb begin
    tmr_en = 1'b0;
    tmr_tc = GAP_TC;
    case (state)
      ST_PRESSED: begin
        tmr_en = 1'b1;
        tmr_tc = LONG_TC;
      end
      ST_LONG_HELD: begin
        tmr_en = 1'b1;
        tmr_tc = REPEAT_TC;
      end
`ifdef BTN_DOUBLE_CLICK_EN
      ST_WAIT_GAP: tmr_en = 1'b1;
`endif
      default: ;
    endcase
  end

  press_timer #(
    .WIDTH(WIDTH_COUNTER)
  ) u_press_timer (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .tc      (tmr_tc),
    .wrap    (tmr_wrap),
    .at_tc   (tmr_at_tc)
  );

  // State register plus registered outputs. btn_prev resets high so a
  // button already held at reset release is not seen as a new press.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= ST_IDLE;
      btn_prev <= 1'b1;
      press_o  <= 1'b0;
      short_o  <= 1'b0;
      long_o   <= 1'b0;
      repeat_o <= 1'b0;
      held_o   <= 1'b0;
    end else begin
      state    <= state_next;
      btn_prev <= btn_i;
      press_o  <= press_d;
      short_o  <= short_d;
      long_o   <= long_d;
      repeat_o <= repeat_d;
      held_o   <= held_d;
    end
  end

  // Next state. A release always wins over a coincident long terminal count,
  // and a second press wins over a coincident gap timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (rise) state_next = ST_PRESSED;
      ST_PRESSED: begin
        if (fall) begin
`ifdef BTN_DOUBLE_CLICK_EN
          state_next = ST_WAIT_GAP;
`else
          state_next = ST_IDLE;
`endif
        end else if (tmr_at_tc && btn_i) begin
          state_next = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: if (fall) state_next = ST_IDLE;
`ifdef BTN_DOUBLE_CLICK_EN
      ST_WAIT_GAP: begin
        if (rise)           state_next = ST_SECOND_HELD;
        else if (tmr_at_tc) state_next = ST_IDLE;
      end
      ST_SECOND_HELD: if (fall) state_next = ST_IDLE;
`endif
      default:      state_next = ST_IDLE;
    endcase
  end

  // Output decode; each branch raises at most one pulse.
  always_comb begin
    press_d  = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    held_d   = is_held_state(state_next);
    case (state)
      ST_IDLE:      press_d = rise;
      ST_PRESSED: begin
        long_d = !fall && tmr_at_tc && btn_i;
`ifndef BTN_DOUBLE_CLICK_EN
        short_d = fall;
`endif
      end
      ST_LONG_HELD: repeat_d = !fall && tmr_at_tc;
`ifdef BTN_DOUBLE_CLICK_EN
      ST_WAIT_GAP:  short_d = !rise && tmr_at_tc;
`endif
      default: ;
    endcase
  end

`ifdef BTN_DOUBLE_CLICK_EN
  logic double_d;
  assign double_d = (state == ST_WAIT_GAP) && rise;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) double_o <= 1'b0;
    else           double_o <= double_d;
  end
`else
  assign double_o = 1'b0;
`endif

endmodule
